music_note_sequencer: RTL and testbench

Plays a song by stepping through the note-duration ROM, one duration entry per note. It holds each note for its encoded number of time units, then advances to the next entry. It sits between the duration ROM, which has a registered 1-cycle read, and the tone generator. Its outputs are the current note index (which also addresses the pitch ROM) and a note-gate signal. A duration of 0 marks end-of-song; the block then stops or loops.

---
 rtl/music_pkg.sv | 15 +
 rtl/music_note_sequencer_if.sv | 26 ++
 rtl/music_unit_timer.sv | 39 +++
 rtl/music_note_sequencer.sv | 128 ++++++++++++
 tb/tb_music_note_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared types and defaults for the note sequencer: FSM states, bus widths
// and the duration code that terminates a song.
package music_pkg;
  localparam int ADDR_W_DEF = 9;
  localparam int DUR_W_DEF  = 8;
  localparam int DUR_END    = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } seq_state_t;
endpackage

// File: rtl/music_note_sequencer_if.sv
// Control, duration-ROM and tone-gate signals of the sequencer; the master side
// is the host plus ROM, the slave side is the sequencer itself.
interface music_note_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DUR_W  = 8
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DUR_W-1:0]  rom_dur;
  logic              note_gate;
  logic              playing;
  logic              song_done;

  modport master (
    output start, stop, pause, loop_en, rom_dur,
    input  rom_addr, note_gate, playing, song_done
  );

  modport slave (
    input  start, stop, pause, loop_en, rom_dur,
    output rom_addr, note_gate, playing, song_done
  );
endinterface

// File: rtl/music_unit_timer.sv
// Tick prescaler dividing the clock into duration units; holds while run is low,
// clears synchronously, and flags whether the next tick lands in the end-of-note gap.
module music_unit_timer #(
  parameter int TICKS_PER_UNIT = 3125000,
  parameter int GAP_TICKS      = 250000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic unit_tick,
  output logic gap_next
);
  localparam int TW = $clog2(TICKS_PER_UNIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [TW-1:0] GAP_FIRST = TW'(TICKS_PER_UNIT - GAP_TICKS);

  logic [TW-1:0] tick;
  logic [TW-1:0] tick_d;

  always_comb begin
    tick_d = tick;
    if (clear)
      tick_d = '0;
    else if (run)
      tick_d = (tick == TICK_LAST) ? '0 : tick + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn)
      tick <= '0;
    else
      tick <= tick_d;
  end

  assign unit_tick = run && !clear && (tick == TICK_LAST);
  // Looks at the value the counter is about to take so the gate can be registered.
  assign gap_next  = (tick_d >= GAP_FIRST);
endmodule

// File: rtl/music_note_sequencer.sv
// Steps through the duration ROM one note at a time, gating the tone generator
// for each note's length minus a short trailing gap; zero duration ends the song.
module music_note_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DUR_W          = DUR_W_DEF,
  parameter int TICKS_PER_UNIT = 3125000,
  parameter int GAP_TICKS      = 250000
) (
  input  logic                  clock,
  input  logic                  resetn,
  music_note_sequencer_if.slave bus
);
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);

  seq_state_t        state;
  logic [ADDR_W-1:0] index;
  logic [DUR_W-1:0]  units;
  logic [DUR_W-1:0]  units_after;
  logic              gate_r;
  logic              playing_r;
  logic              done_r;
  logic              timer_clear;
  logic              timer_run;
  logic              unit_tick;
  logic              gap_next;
  logic              note_end;

  assign timer_run   = (state == S_PLAY) && !bus.stop && !bus.pause;
  assign timer_clear = (state != S_PLAY) || bus.stop;
  assign units_after = unit_tick ? units - 1'b1 : units;
  assign note_end    = unit_tick && (units == DUR_ONE);

  music_unit_timer #(
    .TICKS_PER_UNIT (TICKS_PER_UNIT),
    .GAP_TICKS      (GAP_TICKS)
  ) u_timer (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (timer_clear),
    .run       (timer_run),
    .unit_tick (unit_tick),
    .gap_next  (gap_next)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      index     <= '0;
      units     <= '0;
      gate_r    <= 1'b0;
      playing_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      gate_r <= 1'b0;
      done_r <= 1'b0;
      if (bus.stop) begin
        state     <= S_IDLE;
        index     <= '0;
        units     <= '0;
        playing_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state     <= S_FETCH;
              index     <= '0;
              playing_r <= 1'b1;
            end
          end
          S_FETCH: begin
            if (!bus.pause)
              state <= S_LOAD;
          end
          S_LOAD: begin
            if (!bus.pause) begin
              if (bus.rom_dur == DUR_W'(DUR_END)) begin
                if (bus.loop_en) begin
                  state <= S_FETCH;
                  index <= '0;
                end else begin
                  state     <= S_DONE;
                  playing_r <= 1'b0;
                  done_r    <= 1'b1;
                end
              end else begin
                state  <= S_PLAY;
                units  <= bus.rom_dur;
                gate_r <= !((bus.rom_dur == DUR_ONE) && gap_next);
              end
            end
          end
          S_PLAY: begin
            // While paused the gate drops and the counters hold their place.
            if (!bus.pause) begin
              units <= units_after;
              if (note_end) begin
                if (index == IDX_LAST) begin
                  if (bus.loop_en) begin
                    state <= S_FETCH;
                    index <= '0;
                  end else begin
                    state     <= S_DONE;
                    playing_r <= 1'b0;
                    done_r    <= 1'b1;
                  end
                end else begin
                  state <= S_FETCH;
                  index <= index + 1'b1;
                end
              end else begin
                gate_r <= !((units_after == DUR_ONE) && gap_next);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr  = index;
  assign bus.note_gate = gate_r;
  assign bus.playing   = playing_r;
  assign bus.song_done = done_r;
endmodule

// File: tb/tb_music_note_sequencer.sv
// Drives the sequencer against song-level expected traces built from the ROM
// contents: per-note fetch/load overhead, duration*units of play, trailing gap.
module tb_music_note_sequencer;
  localparam int TPU = 4;
  localparam int GAP = 1;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic pause = 1'b0;
  logic loop_en = 1'b0;
  bit   sel = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] rom1 [16];
  logic [7:0] rom2 [4];
  int model_rom [16];
  int model_depth;
  logic [6:0] exp_q [$];
  int exp_pos;

  always #5 clock = ~clock;

  music_note_sequencer_if #(.ADDR_W(4), .DUR_W(8)) b1 ();
  music_note_sequencer_if #(.ADDR_W(2), .DUR_W(8)) b2 ();

  assign b1.start = start;   assign b2.start = start;
  assign b1.stop = stop;     assign b2.stop = stop;
  assign b1.pause = pause;   assign b2.pause = pause;
  assign b1.loop_en = loop_en; assign b2.loop_en = loop_en;

  always @(posedge clock) begin
    b1.rom_dur <= rom1[b1.rom_addr];
    b2.rom_dur <= rom2[b2.rom_addr];
  end

  music_note_sequencer #(.ADDR_W(4), .DUR_W(8), .TICKS_PER_UNIT(TPU), .GAP_TICKS(GAP)) dut (
    .clock(clock), .resetn(resetn), .bus(b1));

  music_note_sequencer #(.ADDR_W(2), .DUR_W(8), .TICKS_PER_UNIT(TPU), .GAP_TICKS(GAP)) dut_w (
    .clock(clock), .resetn(resetn), .bus(b2));

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [6:0] observe();
    if (sel) return {2'b00, b2.rom_addr, b2.note_gate, b2.playing, b2.song_done};
    return {b1.rom_addr, b1.note_gate, b1.playing, b1.song_done};
  endfunction

  task automatic check(input string tag, input logic [6:0] expv);
    logic [6:0] o;
    o = observe();
    n_checks++;
    assert (o === expv) else begin
      n_fails++;
      $error("FAIL %s: observed addr=%0d gate=%b playing=%b done=%b, expected addr=%0d gate=%b playing=%b done=%b",
             tag, o[6:3], o[2], o[1], o[0], expv[6:3], expv[2], expv[1], expv[0]);
    end
  endtask

  task automatic set_model(input bit s);
    model_depth = s ? 4 : 16;
    for (int i = 0; i < 16; i++) model_rom[i] = 0;
    for (int i = 0; i < model_depth; i++) model_rom[i] = s ? int'(rom2[i]) : int'(rom1[i]);
  endtask

  function automatic void push(input int a, input bit g, input bit p, input bit d);
    exp_q.push_back({4'(a), g, p, d});
  endfunction

  // Song-level model: every note costs two silent cycles, then dur*TPU cycles
  // with the gate dropped for the last GAP of them.
  task automatic build_trace(input bit loop, input int max_len);
    int idx;
    int d;
    exp_q.delete();
    exp_pos = 0;
    idx = 0;
    while (exp_q.size() < max_len) begin
      push(idx, 0, 1, 0);
      push(idx, 0, 1, 0);
      d = model_rom[idx];
      if (d != 0) begin
        for (int c = 0; c < d * TPU; c++) push(idx, c < d * TPU - GAP, 1, 0);
        if (idx < model_depth - 1) begin
          idx++;
          continue;
        end
      end
      if (loop) idx = 0;
      else begin
        push(idx, 0, 0, 1);
        push(idx, 0, 0, 0);
        break;
      end
    end
  endtask

  task automatic run_exp(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_pos < exp_q.size())
        check($sformatf("%s[%0d]", tag, exp_pos), exp_q[exp_pos]);
      exp_pos++;
      tick();
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check(tag, 7'b0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    for (int i = 0; i < 16; i++) rom1[i] = 8'd0;
    rom1[0] = 8'd8; rom1[1] = 8'd6; rom1[2] = 8'd2; rom1[3] = 8'd0;
    for (int i = 0; i < 4; i++) rom2[i] = 8'd1;

    // Reset state
    tick(); tick(); tick();
    check("reset_main", 7'b0);
    sel = 1; check("reset_wrap", 7'b0); sel = 0;
    resetn = 1'b1;
    tick();
    check("idle_after_reset", 7'b0);

    // 1: basic playback, single song_done, then idle in DONE
    set_model(0);
    loop_en = 1'b0;
    build_trace(0, 1000);
    do_start();
    run_exp("basic", exp_q.size());
    check("basic_hold_done", {4'd3, 3'b000});

    // 2: loop back to index 0 with identical note-0 timing, no song_done
    loop_en = 1'b1;
    build_trace(1, 2 + 32 + 2 + 24 + 2 + 8 + 2 + 2 + 32 + 4);
    do_start();
    run_exp("loop", exp_q.size());
    do_stop("loop_stop");
    loop_en = 1'b0;

    // 3: pause 10 cycles in the middle of note 0
    build_trace(0, 1000);
    do_start();
    run_exp("pause_pre", 14);
    pause = 1'b1;
    run_exp("pause_pre", 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) pause = 1'b0;
      check($sformatf("pause_hold[%0d]", i), {4'd0, 3'b010});
      tick();
    end
    run_exp("pause_post", exp_q.size() - exp_pos);

    // 4: stop during note 1, then restart from note 0
    build_trace(0, 1000);
    do_start();
    run_exp("stop_pre", 2 + 32 + 2 + 5);
    do_stop("stop_mid_note");
    check("stop_stays_idle", 7'b0);
    build_trace(0, 1000);
    do_start();
    run_exp("restart", 2 + 32 + 3);
    do_stop("restart_stop");

    // 5: start+stop together in IDLE; start held during PLAY is ignored
    start = 1'b1; stop = 1'b1;
    tick();
    check("start_stop_idle", 7'b0);
    tick();
    check("start_stop_idle2", 7'b0);
    start = 1'b0; stop = 1'b0;
    tick();
    build_trace(0, 1000);
    start = 1'b1;
    tick();
    run_exp("start_in_play", 30);
    start = 1'b0;
    run_exp("start_in_play", exp_q.size() - exp_pos);

    // 6a: reset during PLAY
    build_trace(0, 1000);
    do_start();
    run_exp("rst_pre", 12);
    resetn = 1'b0;
    tick();
    check("rst_mid_play", 7'b0);
    resetn = 1'b1;
    tick();
    check("rst_released", 7'b0);

    // 6b: index wrap on the 2-bit instance, without and with looping
    sel = 1;
    set_model(1);
    build_trace(0, 1000);
    do_start();
    run_exp("wrap_done", exp_q.size());
    loop_en = 1'b1;
    build_trace(1, 4 * (2 + TPU) + 2 + TPU + 2);
    do_start();
    run_exp("wrap_loop", exp_q.size());
    do_stop("wrap_stop");
    loop_en = 1'b0;
    sel = 0;

    // Random songs on the main instance
    for (int r = 0; r < 4; r++) begin
      bit lp;
      len = $urandom_range(1, 5);
      for (int i = 0; i < 16; i++) rom1[i] = 8'd0;
      for (int i = 0; i < len; i++) rom1[i] = 8'($urandom_range(1, 4));
      lp = 1'($urandom_range(0, 1));
      loop_en = lp;
      set_model(0);
      build_trace(lp, lp ? 150 : 1000);
      do_start();
      run_exp($sformatf("rand%0d", r), exp_q.size());
      if (lp) do_stop($sformatf("rand%0d_stop", r));
      loop_en = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
